// File: rtl/lms_pkg.sv
// Shared definitions for the LMS tap sequencer: state encoding and sizing defaults.
package lms_pkg;

    localparam int MAX_TAPS   = 8;
    localparam int NTAPS_DEF  = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int TAP_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_ERR,
        ST_UPD,
        ST_ADV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lms_lrck_sync.sv
// Brings the codec LR clock into the CLOCK_50 domain and flags its falling edge.
module lms_lrck_sync (
    input  logic CLOCK_50,
    input  logic KEY0,
    input  logic AUD_DACLRCK,
    output logic strobe
);

    logic sync1, sync2, hist;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= AUD_DACLRCK;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Flops reset low, so releasing reset with the LR clock low cannot fake an edge.
    assign strobe = hist & ~sync2;

endmodule

// File: rtl/lms_tap_sequencer.sv
// Sequences one LMS sample: load, NTAPS-cycle MAC, error latch, NTAPS-cycle weight update, advance.
module lms_tap_sequencer
    import lms_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              KEY0,
    input  logic              AUD_DACLRCK,
    input  logic              freeze,
    output logic              busy,
    output logic              smp_we,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              err_latch,
    output logic              w_we,
    output logic [ADDR_W-1:0] base,
    output logic              out_valid,
    output logic              overrun
);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

    state_t state_q, state_d;
    logic   strobe;
    logic   tap_clr, tap_step, base_inc, ovr_set;

    lms_lrck_sync u_sync (
        .CLOCK_50    (CLOCK_50),
        .KEY0        (KEY0),
        .AUD_DACLRCK (AUD_DACLRCK),
        .strobe      (strobe)
    );

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        smp_we    = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        err_latch = 1'b0;
        w_we      = 1'b0;
        out_valid = 1'b0;
        tap_clr   = 1'b0;
        tap_step  = 1'b0;
        base_inc  = 1'b0;
        ovr_set   = strobe && (state_q != ST_IDLE) && (state_q != ST_DONE);
        case (state_q)
            ST_IDLE: if (strobe) state_d = ST_LOAD;
            ST_LOAD: begin
                busy    = 1'b1;
                smp_we  = 1'b1;
                acc_clr = 1'b1;
                tap_clr = 1'b1;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                busy   = 1'b1;
                acc_en = 1'b1;
                // Counter parks on the last tap; ERR restarts it for the update pass.
                if (tap_idx == LAST_TAP) state_d = ST_ERR;
                else                     tap_step = 1'b1;
            end
            ST_ERR: begin
                busy      = 1'b1;
                err_latch = 1'b1;
                tap_clr   = 1'b1;
                state_d   = ST_UPD;
            end
            ST_UPD: begin
                busy = 1'b1;
                w_we = ~freeze;
                if (tap_idx == LAST_TAP) state_d = ST_ADV;
                else                     tap_step = 1'b1;
            end
            ST_ADV: begin
                busy     = 1'b1;
                base_inc = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                state_d   = strobe ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rd_addr tracks base - tap_idx incrementally so it holds its value while base advances.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            tap_idx <= '0;
            rd_addr <= '0;
            base    <= '0;
            overrun <= 1'b0;
        end else begin
            if (tap_clr) begin
                tap_idx <= '0;
                rd_addr <= base;
            end else if (tap_step) begin
                tap_idx <= tap_idx + 1'b1;
                rd_addr <= rd_addr - 1'b1;
            end
            if (base_inc) base    <= base + 1'b1;
            if (ovr_set)  overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lms_tap_sequencer.sv
// Randomized scoreboard bench for lms_tap_sequencer against a sample-level timing model.
module tb_lms_tap_sequencer;

    localparam int N    = 8;
    localparam int AW   = 4;
    localparam int LAT  = 2 * N + 4;
    localparam int HMAX = 8192;

    logic          CLOCK_50 = 1'b0;
    logic          KEY0 = 1'b1;
    logic          AUD_DACLRCK = 1'b0;
    logic          freeze = 1'b0;
    logic          busy, smp_we, acc_clr, acc_en, err_latch, w_we, out_valid, overrun;
    logic [AW-1:0] rd_addr, base;
    logic [2:0]    tap_idx;

    lms_tap_sequencer #(.NTAPS(N), .ADDR_W(AW)) dut (
        .CLOCK_50    (CLOCK_50),
        .KEY0        (KEY0),
        .AUD_DACLRCK (AUD_DACLRCK),
        .freeze      (freeze),
        .busy        (busy),
        .smp_we      (smp_we),
        .rd_addr     (rd_addr),
        .tap_idx     (tap_idx),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .err_latch   (err_latch),
        .w_we        (w_we),
        .base        (base),
        .out_valid   (out_valid),
        .overrun     (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {int s; int b;} exp_t;
    exp_t q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int next_free = 0, drop_cyc = -1, m_base = 0;
    int freeze_mode = 0;

    logic          h_smp [HMAX];
    logic          h_acc [HMAX];
    logic          h_err [HMAX];
    logic          h_wwe [HMAX];
    logic          h_busy[HMAX];
    logic          h_frz [HMAX];
    logic [AW-1:0] h_rd  [HMAX];
    logic [2:0]    h_tap [HMAX];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
    end

    // freeze changes just after each edge and is logged against the cycle it governs
    initial forever begin
        @(posedge CLOCK_50);
        #2;
        case (freeze_mode)
            0:       freeze = 1'b0;
            1:       freeze = 1'b1;
            default: freeze = 1'($urandom_range(0, 1));
        endcase
        if (cyc < HMAX) h_frz[cyc] = freeze;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #2;
        end
    endtask

    // Reference model: a fall driven in cycle c is seen as a strobe in cycle c+2.
    // It starts a sample if the previous one has reached its final cycle, otherwise it is dropped.
    task automatic note_fall(input int c);
        int s;
        s = c + 2;
        if (s >= next_free) begin
            q.push_back('{s, m_base});
            m_base    = (m_base + 1) % (1 << AW);
            next_free = s + LAT;
        end else if (drop_cyc < 0) begin
            drop_cyc = s;
        end
    endtask

    task automatic lrck_seq(input int gap);
        int lo;
        lo = gap / 2;
        step(lo);
        AUD_DACLRCK = 1'b1;
        step(gap - lo);
        AUD_DACLRCK = 1'b0;
        note_fall(cyc);
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {busy, smp_we, acc_clr, acc_en, err_latch, w_we, out_valid, overrun,
                 base, rd_addr, tap_idx}, 0);
    endtask

    task automatic model_reset();
        q.delete();
        next_free = 0;
        drop_cyc  = -1;
        m_base    = 0;
    endtask

    task automatic check_seq(input int c);
        exp_t e;
        int s, b, cnt, cnt2, u;
        e = q.pop_front();
        s = e.s;
        b = e.b;
        chk("out_valid_latency", c - s, LAT);
        cnt = 0;
        for (int i = s + 1; i <= c; i++) cnt += int'(h_smp[i]);
        chk("smp_we_count", cnt, 1);
        chk("smp_we_cycle", h_smp[s + 1], 1);
        cnt = 0; cnt2 = 0;
        for (int i = s + 1; i <= c; i++) cnt += int'(h_acc[i]);
        for (int k = 0; k < N; k++) begin
            u = s + 2 + k;
            cnt2 += int'(h_acc[u]);
            chk("mac_rd_addr", h_rd[u], ((b - k) % 16 + 16) % 16);
            chk("mac_tap_idx", h_tap[u], k);
        end
        chk("acc_en_total", cnt, N);
        chk("acc_en_window", cnt2, N);
        cnt = 0;
        for (int i = s + 1; i <= c; i++) cnt += int'(h_err[i]);
        chk("err_latch_count", cnt, 1);
        chk("err_latch_cycle", h_err[s + N + 2], 1);
        cnt = 0; cnt2 = 0;
        for (int i = s + 1; i <= c; i++) cnt += int'(h_wwe[i]);
        for (int k = 0; k < N; k++) begin
            u = s + N + 3 + k;
            cnt2 += int'(!h_frz[u]);
            chk("upd_rd_addr", h_rd[u], ((b - k) % 16 + 16) % 16);
            chk("upd_tap_idx", h_tap[u], k);
            chk("upd_w_we", h_wwe[u], !h_frz[u]);
        end
        chk("w_we_total", cnt, cnt2);
        cnt = 0;
        for (int i = s + 1; i <= s + 2 * N + 3; i++) cnt += int'(h_busy[i]);
        chk("busy_span", cnt, 2 * N + 3);
        chk("busy_in_done", h_busy[c], 0);
        chk("base_after_adv", base, (b + 1) % 16);
        chk("overrun_flag", overrun, (drop_cyc >= 0 && drop_cyc < c) ? 1 : 0);
    endtask

    // Monitor: logs every cycle, retires one expected sample per out_valid
    initial forever begin
        int c;
        @(negedge CLOCK_50);
        c = cyc;
        if (c < HMAX) begin
            h_smp[c]  = smp_we;
            h_acc[c]  = acc_en;
            h_err[c]  = err_latch;
            h_wwe[c]  = w_we;
            h_busy[c] = busy;
            h_rd[c]   = rd_addr;
            h_tap[c]  = tap_idx;
        end
        if (q.size() == 0)
            chk("unexpected_pulse", {smp_we, out_valid}, 0);
        else if (out_valid && c < HMAX)
            check_seq(c);
    end

    initial begin
        #3 KEY0 = 1'b0;
        #1 chk_zero("reset_state");
        step(3);
        KEY0 = 1'b1;

        // released with LR clock low: nothing may start
        repeat (100) begin
            step(1);
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_pulses", {smp_we, acc_clr, acc_en, err_latch, w_we, out_valid}, 0);
        end

        lrck_seq(6);
        step(30);
        chk("base_after_first", base, 1);

        // second strobe lands in the DONE cycle of the first
        lrck_seq(6);
        lrck_seq(LAT);
        step(30);
        chk("overrun_clean", overrun, 0);

        freeze_mode = 1;
        lrck_seq(6);
        step(30);
        freeze_mode = 0;

        lrck_seq(6);
        lrck_seq(5);
        step(30);
        chk("overrun_sticky", overrun, 1);

        freeze_mode = 2;
        repeat (40) lrck_seq(int'($urandom_range(6, 34)));
        step(40);
        freeze_mode = 0;

        // reset in the middle of the MAC phase
        lrck_seq(6);
        step(6);
        #1 KEY0 = 1'b0;
        #1 chk_zero("reset_mid_mac");
        model_reset();
        step(3);
        KEY0 = 1'b1;
        step(40);

        lrck_seq(6);
        step(30);
        chk("base_after_reset_seq", base, 1);

        step(5);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/lms_tap_sequencer.md
LMS_TAP_SEQUENCER -- requirements
Module: lms_tap_sequencer

Interface
REQ-001 Parameter NTAPS, default 8, number of adaptive taps; legal range 2..8.
REQ-002 Parameter ADDR_W, default 4, circular-buffer address width (depth 16).
REQ-003 CLOCK_50  in  1  system clock; all state on its rising edge.
REQ-004 KEY0  in  1  reset, asynchronous, active-low.
REQ-005 AUD_DACLRCK  in  1  codec LR clock, asynchronous to CLOCK_50; its falling edge is the sample strobe.
REQ-006 freeze  in  1  level; 1 suppresses weight updates.
REQ-007 busy  out  1  high from LOAD through ADV inclusive.
REQ-008 smp_we  out  1  one-cycle pulse; datapath writes new reference sample at address base.
REQ-009 rd_addr  out  ADDR_W  circular-buffer read address for the current tap.
REQ-010 tap_idx  out  3  current tap index k, 0 = newest sample.
REQ-011 acc_clr  out  1  one-cycle pulse; clear the MAC accumulator.
REQ-012 acc_en  out  1  accumulate product w[k]*x[rd_addr].
REQ-013 err_latch  out  1  one-cycle pulse; latch error = primary - accumulator.
REQ-014 w_we  out  1  write the updated weight w[tap_idx].
REQ-015 base  out  ADDR_W  circular-buffer write pointer.
REQ-016 out_valid  out  1  one-cycle pulse; the error output is valid.
REQ-017 overrun  out  1  sticky; a strobe was dropped.

Function
REQ-018 AUD_DACLRCK shall pass through a 2-flop synchronizer and a third history flop; strobe = history 1 and synchronized 0, one CLOCK_50 cycle wide.
REQ-019 States: IDLE, LOAD, MAC, ERR, UPD, ADV, DONE.
REQ-020 IDLE->LOAD on strobe; otherwise remain in IDLE.
REQ-021 LOAD, 1 cycle: assert smp_we and acc_clr; tap_idx <= 0.
REQ-022 MAC, NTAPS cycles: acc_en=1; tap_idx steps 0..NTAPS-1; rd_addr = (base - tap_idx) mod 2^ADDR_W.
REQ-023 ERR, 1 cycle: assert err_latch; tap_idx <= 0.
REQ-024 UPD, NTAPS cycles: tap_idx steps 0..NTAPS-1; rd_addr per REQ-022; w_we = ~freeze.
REQ-025 ADV, 1 cycle: base <= (base + 1) mod 2^ADDR_W; wrap 15->0 without error.
REQ-026 DONE, 1 cycle: assert out_valid; go to LOAD if a strobe is present in this cycle, else go to IDLE.
REQ-027 Strobe-to-out_valid latency: 2*NTAPS+4 cycles, i.e. 20 cycles at NTAPS=8.
REQ-028 A strobe in any state other than IDLE or DONE shall be dropped and shall set overrun; the current sequence continues unaffected.
REQ-029 Outside their states, smp_we, acc_clr, acc_en, err_latch, w_we and out_valid shall be 0; tap_idx and rd_addr hold their last values.
REQ-030 freeze sampled per UPD cycle; toggling mid-UPD gates individual w_we cycles only, with no change in timing.
REQ-031 All address arithmetic modulo 2^ADDR_W; tap_idx counter width 3; no saturation.

Reset
REQ-032 KEY0 low shall immediately force state IDLE, base 0, tap_idx 0, rd_addr 0, all pulse outputs 0, busy 0, overrun 0, synchronizer/history flops 0.
REQ-033 Because the flops reset to 0, release with AUD_DACLRCK low shall not create a strobe; the first strobe is the first falling edge after release.
REQ-034 Reset mid-sequence shall abandon the sequence with no further w_we or out_valid.

Structure
REQ-035 Shared package lms_pkg shall hold the state enumeration, NTAPS/ADDR_W defaults and the MAX_TAPS=8 constant.
REQ-036 Sub-module lms_lrck_sync (synchronizer plus falling-edge detector) shall be instantiated once; all else is flat.

Verification
REQ-037 Reset release with AUD_DACLRCK low, no edge for 100 cycles -> busy stays 0, no pulses.
REQ-038 Single falling edge, NTAPS=8, base=0 -> smp_we at cycle 1 after strobe, rd_addr sequence 0,15,14..9 in MAC and again in UPD, 8 w_we, out_valid at strobe+20, base=1.
REQ-039 16 consecutive samples -> base wraps 15->0; rd_addr at base=2 is 2,1,0,15,14,13,12,11.
REQ-040 Second strobe 5 cycles after the first -> overrun=1 and remains 1; the first sequence completes normally; the second produces no smp_we.
REQ-041 Strobe coincident with DONE -> LOAD on the next cycle, overrun stays 0.
REQ-042 freeze=1 for the entire UPD phase -> zero w_we and identical timing; reset asserted during MAC -> all outputs 0 asynchronously and no out_valid.
